// File: rtl/keypad_bcd_encoder.sv
// Keypad scanner and BCD encoder for a 4x3 matrix keypad.
// Drives one column low at a time, samples the four rows through a
// two-flop synchronizer, assembles a 12-bit scan image, decodes it to a
// BCD key code, and runs a debounce FSM. The FSM emits each accepted press
// once as a one-cycle BCD_valid strobe.
//
// Handshake: BCD_valid is a one-cycle strobe qualifying BCD_out. There is
// no ready; the consumer must capture BCD_out in the cycle BCD_valid is high.
module keypad_bcd_encoder #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] row_in,
  output logic [2:0] col_out,
  output logic [3:0] BCD_out,
  output logic       BCD_valid,
  output logic       key_held,
  output logic [1:0] o_dbg_state
);

  localparam int              DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB        = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PRESS_CAND = 2'd1,
    S_PRESSED    = 2'd2,
    S_REL_CAND   = 2'd3
  } state_t;

  // Scanner state
  logic [3:0]    r_row_s1;
  logic [3:0]    r_row_s2;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col;
  logic [11:0]   r_img;
  logic [11:0]   r_snap;
  logic          r_scan_done;
  logic [11:0]   w_img_sampled;

  // Decode results
  logic [3:0]    w_ones;
  logic [3:0]    w_code;
  logic          w_code_ok;
  logic          w_none;

  // Debounce FSM state and next values
  state_t        r_state;
  state_t        w_state;
  logic [3:0]    r_cand;
  logic [3:0]    w_cand;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt;
  logic [3:0]    w_cnt_inc;
  logic [3:0]    r_bcd;
  logic [3:0]    w_bcd;
  logic          r_valid;
  logic          w_valid;
  logic          r_held;
  logic          w_held;

  // Column drive: one-cold, column 0 is bit 0.
  always_comb begin
    case (r_col)
      2'd0:    col_out = 3'b110;
      2'd1:    col_out = 3'b101;
      default: col_out = 3'b011;
    endcase
  end

  // Working image with the current column's inverted rows merged in.
  // Bit layout: image[col*4 + row].
  always_comb begin
    w_img_sampled = r_img;
    case (r_col)
      2'd0:    w_img_sampled[3:0]  = ~r_row_s2;
      2'd1:    w_img_sampled[7:4]  = ~r_row_s2;
      default: w_img_sampled[11:8] = ~r_row_s2;
    endcase
  end

  // Synchronizer, dwell/column counters, scan image and snapshot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_row_s1    <= 4'b0000;
      r_row_s2    <= 4'b0000;
      r_dwell     <= '0;
      r_col       <= 2'd0;
      r_img       <= 12'h000;
      r_snap      <= 12'h000;
      r_scan_done <= 1'b0;
    end else begin
      r_row_s1    <= row_in;
      r_row_s2    <= r_row_s1;
      r_scan_done <= 1'b0;
      if (r_dwell == DWELL_LAST) begin
        r_dwell <= '0;
        if (r_col == 2'd2) begin
          r_col       <= 2'd0;
          r_snap      <= w_img_sampled;
          r_img       <= 12'h000;
          r_scan_done <= 1'b1;
        end else begin
          r_col <= r_col + 2'd1;
          r_img <= w_img_sampled;
        end
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
    end
  end

  // Snapshot decode: single key, star+hash chord, or none/ghost.
  always_comb begin
    w_ones    = 4'd0;
    w_code    = 4'b0000;
    w_code_ok = 1'b0;
    w_none    = (r_snap == 12'h000);
    for (int i = 0; i < 12; i++) begin
      w_ones = w_ones + {3'b000, r_snap[i]};
    end
    if (w_ones == 4'd1) begin
      w_code_ok = 1'b1;
      case (r_snap)
        12'h001: w_code = 4'd1;
        12'h002: w_code = 4'd4;
        12'h004: w_code = 4'd7;
        12'h008: w_code = 4'b1011;
        12'h010: w_code = 4'd2;
        12'h020: w_code = 4'd5;
        12'h040: w_code = 4'd8;
        12'h080: w_code = 4'd0;
        12'h100: w_code = 4'd3;
        12'h200: w_code = 4'd6;
        12'h400: w_code = 4'd9;
        default: w_code = 4'b1100;
      endcase
    end else if (r_snap == 12'h808) begin
      w_code_ok = 1'b1;
      w_code    = 4'b1101;
    end
  end

  // Debounce FSM next-state and output logic; only acts on scan_done.
  always_comb begin
    w_state   = r_state;
    w_cand    = r_cand;
    w_cnt     = r_cnt;
    w_bcd     = r_bcd;
    w_valid   = 1'b0;
    w_held    = r_held;
    w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    if (r_scan_done) begin
      case (r_state)
        S_IDLE: begin
          if (w_code_ok) begin
            w_cand = w_code;
            w_cnt  = 4'd1;
            if (DEB <= 4'd1) begin
              w_bcd   = w_code;
              w_valid = 1'b1;
              w_held  = 1'b1;
              w_state = S_PRESSED;
            end else begin
              w_state = S_PRESS_CAND;
            end
          end
        end
        S_PRESS_CAND: begin
          if (w_code_ok) begin
            if (w_code == r_cand) begin
              w_cnt = w_cnt_inc;
              if (w_cnt_inc >= DEB) begin
                w_bcd   = r_cand;
                w_valid = 1'b1;
                w_held  = 1'b1;
                w_state = S_PRESSED;
              end
            end else begin
              w_cand = w_code;
              w_cnt  = 4'd1;
            end
          end else begin
            w_cnt   = 4'd0;
            w_state = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (w_none) begin
            w_cnt = 4'd1;
            if (DEB <= 4'd1) begin
              w_held  = 1'b0;
              w_state = S_IDLE;
            end else begin
              w_state = S_REL_CAND;
            end
          end
        end
        default: begin
          if (w_none) begin
            w_cnt = w_cnt_inc;
            if (w_cnt_inc >= DEB) begin
              w_cnt   = 4'd0;
              w_held  = 1'b0;
              w_state = S_IDLE;
            end
          end else begin
            w_state = S_PRESSED;
          end
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cand  <= 4'd0;
      r_cnt   <= 4'd0;
      r_bcd   <= 4'd0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cand  <= w_cand;
      r_cnt   <= w_cnt;
      r_bcd   <= w_bcd;
      r_valid <= w_valid;
      r_held  <= w_held;
    end
  end

  assign BCD_out     = r_bcd;
  assign BCD_valid   = r_valid;
  assign key_held    = r_held;
  assign o_dbg_state = r_state;

endmodule
